// File: rtl/input_debouncer_if.sv
// Purpose: groups the debouncer's noisy input, enable and debounced outputs into one bundle.
// Latency: none; this is wiring only.
// Backpressure: none; the master drives raw_in/enable and the slave drives the status outputs.
interface input_debouncer_if;
  logic raw_in;
  logic enable;
  logic d_out;
  logic rise;
  logic fall;
  logic busy;

  // The testbench or surrounding logic drives the input and reads the results.
  modport master (
    output raw_in,
    output enable,
    input  d_out,
    input  rise,
    input  fall,
    input  busy
  );

  // The debouncer reads the input and drives the results.
  modport slave (
    input  raw_in,
    input  enable,
    output d_out,
    output rise,
    output fall,
    output busy
  );
endinterface

// File: rtl/input_debouncer.sv
// Purpose: synchronize and debounce a noisy level input; emit one-cycle edge pulses.
// Latency: a clean step before edge N shows on d_out after edge N+STABLE_COUNT+1.
// Backpressure: enable=0 freezes the counter and d_out; the synchronizer keeps sampling.
module input_debouncer #(
  parameter int STABLE_COUNT = 8,
  parameter int CNT_WIDTH    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input_debouncer_if.slave  bus
);

  // Final counter value; the edge that finds the count here commits the new level.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

  logic                 sync1_q;
  logic                 sync2_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 d_out_q;
  logic                 d_out_d;
  logic                 rise_q;
  logic                 rise_d;
  logic                 fall_q;
  logic                 fall_d;

  // Two-flop synchronizer; sync2_q is the only copy of raw_in the logic looks at.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.raw_in;
      sync2_q <= sync1_q;
    end
  end

  // Next-state: count while the synchronized input disagrees with d_out, clear on agreement.
  always_comb begin
    count_d = count_q;
    d_out_d = d_out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (bus.enable) begin
      if (sync2_q != d_out_q) begin
        // Using >= rather than == means a corrupted count can never wrap past the limit.
        if (count_q >= CNT_LAST) begin
          d_out_d = sync2_q;
          count_d = '0;
          rise_d  = sync2_q;
          fall_d  = ~sync2_q;
        end else begin
          count_d = count_q + CNT_WIDTH'(1);
        end
      end else begin
        // Input agrees with the committed level: any partial count was a glitch.
        count_d = '0;
      end
    end
  end

  // State registers; reset discards any partial count and suppresses pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      d_out_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      d_out_q <= d_out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.d_out = d_out_q;
  assign bus.rise  = rise_q;
  assign bus.fall  = fall_q;
  assign bus.busy  = (count_q != '0);

  // The edge pulses are mutually exclusive by construction.
  a_pulse_exclusive : assert property (@(posedge clock) disable iff (reset) !(rise_q && fall_q));

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter STABLE_COUNT, default 8: the number of consecutive clock cycles the synchronized input must differ from d_out before d_out changes.
REQ-002 SHALL have parameter CNT_WIDTH, default 4: the stability counter width; must satisfy 2^CNT_WIDTH > STABLE_COUNT-1.
REQ-003 SHALL have port: clock, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port: raw_in, input, 1, asynchronous noisy level input (switch/button).
REQ-006 SHALL have port: enable, input, 1, counting enable; when low, the counter and outputs hold.
REQ-007 SHALL have port: d_out, output, 1, debounced level, registered; intended to drive a downstream flip-flop d input.
REQ-008 SHALL have port: rise, output, 1, one-cycle registered pulse when d_out goes 0->1.
REQ-009 SHALL have port: fall, output, 1, one-cycle registered pulse when d_out goes 1->0.
REQ-010 SHALL have port: busy, output, 1, high exactly when the stability counter is nonzero.

Function
REQ-011 SHALL pass raw_in through a two-flop synchronizer (sync1 then sync2); sync2 is the only internal copy of raw_in used.
REQ-012 SHALL, on each edge with enable=1 where sync2 != d_out and count < STABLE_COUNT-1, increment count by 1.
REQ-013 SHALL, on the edge with enable=1 where sync2 != d_out and count == STABLE_COUNT-1, load d_out <= sync2 and count <= 0, and assert rise or fall (matching direction) for that cycle only.
REQ-014 SHALL, on any edge with enable=1 where sync2 == d_out, load count <= 0 (glitch rejection).
REQ-015 SHALL, with enable=0, hold count and d_out and drive rise=fall=0; sync1/sync2 continue to sample.
REQ-016 SHALL deassert rise and fall on every edge not covered by REQ-013; rise and fall are never high together.
REQ-017 SHALL have a latency for a clean step applied before edge N of d_out changing on edge N+STABLE_COUNT+1 (edge 9 after the first capture edge for the default).
REQ-018 SHALL leave d_out unchanged for a pulse on sync2 lasting fewer than STABLE_COUNT cycles; count returns to 0 on the first edge the pulse ends.
REQ-019 SHALL never wrap count; its maximum value is STABLE_COUNT-1.

Reset
REQ-020 SHALL, while reset=1, asynchronously force sync1=sync2=0, count=0, d_out=0, rise=fall=0, and busy=0, independent of clock.
REQ-021 SHALL discard any partial count when reset is asserted mid-count and generate no pulse.
REQ-022 SHALL, if raw_in=1 when reset deasserts, treat it as a new 0->1 step: full REQ-017 latency followed by one rise pulse.

Verification
REQ-023 SHALL be verified: clean step with clock period 20, STABLE_COUNT=8, raw_in 0->1 before edge 1, held -> d_out=1 after edge 10, rise high for one cycle only, busy high after edges 3-9.
REQ-024 SHALL be verified: raw_in high for 3 cycles then low -> d_out stays 0, no rise, count back to 0, busy low.
REQ-025 SHALL be verified: with d_out=1, raw_in 1->0 held -> fall is a single one-cycle pulse with the same latency as REQ-023 and d_out=0.
REQ-026 SHALL be verified: enable dropped for 5 cycles mid-count (count=4) -> count held at 4, then resumes; d_out changes 5 cycles later than in REQ-023.
REQ-027 SHALL be verified: reset pulsed asynchronously between edges at count=6 -> all outputs 0 immediately, no pulse; raw_in still 1 -> rise after full latency from reset release.
REQ-028 SHALL be verified: raw_in toggling every cycle for 40 cycles -> d_out constant, rise=fall=0 throughout.
